// File: rtl/mccu_cfg_pkg.sv
// mccu_cfg_pkg: shared definitions for the MCCU configuration register block.
//   - byte offsets of the register map
//   - CTRL bit positions
//   - request/response FSM state encoding
package mccu_cfg_pkg;

  localparam logic [31:0] ADDR_CTRL       = 32'h00;
  localparam logic [31:0] ADDR_IRQ_STATUS = 32'h04;
  localparam logic [31:0] ADDR_IRQ_MASK   = 32'h08;
  localparam logic [31:0] QUOTA_BASE      = 32'h10;
  localparam logic [31:0] WEIGHT_BASE     = 32'h40;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_COMMIT_BIT = 1;

  typedef enum logic [0:0] {
    IDLE,
    RESP
  } state_t;

endpackage

// File: rtl/mccu_cfg_decode.sv
// mccu_cfg_decode: combinational address decoder for mccu_cfg_regs.
// Ports:
//   addr_i        byte address of the current request
//   sel_ctrl_o    CTRL register hit
//   sel_stat_o    IRQ_STATUS register hit
//   sel_mask_o    IRQ_MASK register hit
//   sel_quota_o   QUOTA[core_idx_o] hit
//   core_idx_o    quota core index
//   sel_weight_o  WEIGHT[weight_idx_o] hit (flat index c*CORE_EVENTS+e)
//   weight_idx_o  flat weight index
//   err_o         misaligned or unmapped address
module mccu_cfg_decode
  import mccu_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned N_CORES     = 2,
  parameter int unsigned CORE_EVENTS = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  sel_ctrl_o,
  output logic                  sel_stat_o,
  output logic                  sel_mask_o,
  output logic                  sel_quota_o,
  output logic [3:0]            core_idx_o,
  output logic                  sel_weight_o,
  output logic [5:0]            weight_idx_o,
  output logic                  err_o
);

  localparam int unsigned N_W = N_CORES * CORE_EVENTS;

  logic [31:0] addr_ext;
  logic [31:0] q_off;
  logic [31:0] w_off;
  logic        aligned;

  always_comb begin
    addr_ext     = 32'(addr_i);
    aligned      = (addr_ext[1:0] == 2'b00);
    q_off        = addr_ext - QUOTA_BASE;
    w_off        = addr_ext - WEIGHT_BASE;
    core_idx_o   = 4'(q_off >> 2);
    weight_idx_o = 6'(w_off >> 2);
    sel_ctrl_o   = aligned && (addr_ext == ADDR_CTRL);
    sel_stat_o   = aligned && (addr_ext == ADDR_IRQ_STATUS);
    sel_mask_o   = aligned && (addr_ext == ADDR_IRQ_MASK);
    sel_quota_o  = aligned && (addr_ext >= QUOTA_BASE) &&
                   (addr_ext < QUOTA_BASE + 32'(4 * N_CORES));
    sel_weight_o = aligned && (addr_ext >= WEIGHT_BASE) &&
                   (addr_ext < WEIGHT_BASE + 32'(4 * N_W));
    err_o        = !(sel_ctrl_o || sel_stat_o || sel_mask_o ||
                     sel_quota_o || sel_weight_o);
  end

endmodule

// File: rtl/mccu_cfg_regs.sv
// mccu_cfg_regs: software register port for the MCCU.
// Owns per-core quota and per-event weight registers, the MCCU enable, and a
// sticky/maskable IRQ status aggregated into a single registered irq_o.
// Optional build macro MCCU_CFG_SHADOW_EN: quota/weight writes go to shadow
// registers, copied to the outputs atomically by a CTRL write with COMMIT=1.
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   req_valid_i/ready_o     request handshake (we, addr, wdata)
//   rsp_valid_o/ready_i     response handshake (rdata, err)
//   mccu_en_o               CTRL.EN
//   quota_o                 core c at [c*DATA_WIDTH +: DATA_WIDTH]
//   weights_o               weight c*CORE_EVENTS+e at [i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH]
//   mccu_irq_i              per-core level interrupts from the MCCU
//   irq_o                   |(IRQ_STATUS & IRQ_MASK), registered
module mccu_cfg_regs
  import mccu_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned WEIGHTS_WIDTH = 10,
  parameter int unsigned N_CORES       = 2,
  parameter int unsigned CORE_EVENTS   = 4,
  parameter int unsigned ADDR_WIDTH    = 8
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    req_valid_i,
  output logic                                    req_ready_o,
  input  logic                                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]                   req_addr_i,
  input  logic [DATA_WIDTH-1:0]                   req_wdata_i,
  output logic                                    rsp_valid_o,
  input  logic                                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]                   rsp_rdata_o,
  output logic                                    rsp_err_o,
  output logic                                    mccu_en_o,
  output logic [N_CORES*DATA_WIDTH-1:0]           quota_o,
  output logic [N_CORES*CORE_EVENTS*WEIGHTS_WIDTH-1:0] weights_o,
  input  logic [N_CORES-1:0]                      mccu_irq_i,
  output logic                                    irq_o
);

  localparam int unsigned N_W = N_CORES * CORE_EVENTS;

  state_t state_q, state_nxt;

  logic                     dec_sel_ctrl, dec_sel_stat, dec_sel_mask;
  logic                     dec_sel_quota, dec_sel_weight, dec_err;
  logic [3:0]               dec_core;
  logic [5:0]               dec_widx;

  logic                     accept, wr_ok;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [N_CORES-1:0]       stat_clr;

  logic                     en_q;
  logic [N_CORES-1:0]       status_q, mask_q;
  logic                     irq_q;
  logic [DATA_WIDTH-1:0]    rsp_rdata_q;
  logic                     rsp_err_q;
  logic [DATA_WIDTH-1:0]    quota_q  [N_CORES];
  logic [WEIGHTS_WIDTH-1:0] weight_q [N_W];
`ifdef MCCU_CFG_SHADOW_EN
  logic [DATA_WIDTH-1:0]    quota_sh  [N_CORES];
  logic [WEIGHTS_WIDTH-1:0] weight_sh [N_W];
`endif

  mccu_cfg_decode #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .N_CORES     (N_CORES),
    .CORE_EVENTS (CORE_EVENTS)
  ) u_decode (
    .addr_i       (req_addr_i),
    .sel_ctrl_o   (dec_sel_ctrl),
    .sel_stat_o   (dec_sel_stat),
    .sel_mask_o   (dec_sel_mask),
    .sel_quota_o  (dec_sel_quota),
    .core_idx_o   (dec_core),
    .sel_weight_o (dec_sel_weight),
    .weight_idx_o (dec_widx),
    .err_o        (dec_err)
  );

  // ready is gated by rst_i so it reads 0 while reset is asserted
  always_comb begin
    state_nxt   = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = !rst_i;
        if (req_valid_i && !rst_i) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    accept   = req_valid_i && req_ready_o;
    wr_ok    = accept && req_we_i && !dec_err;
    stat_clr = (wr_ok && dec_sel_stat) ? req_wdata_i[N_CORES-1:0] : '0;
  end

  always_comb begin
    rd_data = '0;
    if (dec_sel_ctrl) rd_data[CTRL_EN_BIT] = en_q;
    if (dec_sel_stat) rd_data = DATA_WIDTH'(status_q);
    if (dec_sel_mask) rd_data = DATA_WIDTH'(mask_q);
    if (dec_sel_quota) begin
      for (int unsigned c = 0; c < N_CORES; c++) begin
`ifdef MCCU_CFG_SHADOW_EN
        if (32'(dec_core) == c) rd_data = quota_sh[c];
`else
        if (32'(dec_core) == c) rd_data = quota_q[c];
`endif
      end
    end
    if (dec_sel_weight) begin
      for (int unsigned i = 0; i < N_W; i++) begin
`ifdef MCCU_CFG_SHADOW_EN
        if (32'(dec_widx) == i) rd_data = DATA_WIDTH'(weight_sh[i]);
`else
        if (32'(dec_widx) == i) rd_data = DATA_WIDTH'(weight_q[i]);
`endif
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q        <= 1'b0;
      status_q    <= '0;
      mask_q      <= '0;
      irq_q       <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int unsigned c = 0; c < N_CORES; c++) quota_q[c] <= '0;
      for (int unsigned i = 0; i < N_W; i++) weight_q[i] <= '0;
`ifdef MCCU_CFG_SHADOW_EN
      for (int unsigned c = 0; c < N_CORES; c++) quota_sh[c] <= '0;
      for (int unsigned i = 0; i < N_W; i++) weight_sh[i] <= '0;
`endif
    end else begin
      // set is OR-ed after the clear so a simultaneous interrupt wins
      status_q <= (status_q & ~stat_clr) | mccu_irq_i;
      irq_q    <= |(status_q & mask_q);

      if (accept) begin
        rsp_rdata_q <= (req_we_i || dec_err) ? '0 : rd_data;
        rsp_err_q   <= dec_err;
      end

      if (wr_ok && dec_sel_mask) mask_q <= req_wdata_i[N_CORES-1:0];

      if (wr_ok && dec_sel_ctrl) begin
        en_q <= req_wdata_i[CTRL_EN_BIT];
`ifdef MCCU_CFG_SHADOW_EN
        if (req_wdata_i[CTRL_COMMIT_BIT]) begin
          for (int unsigned c = 0; c < N_CORES; c++) quota_q[c] <= quota_sh[c];
          for (int unsigned i = 0; i < N_W; i++) weight_q[i] <= weight_sh[i];
        end
`endif
      end

      for (int unsigned c = 0; c < N_CORES; c++) begin
        if (wr_ok && dec_sel_quota && (32'(dec_core) == c)) begin
`ifdef MCCU_CFG_SHADOW_EN
          quota_sh[c] <= req_wdata_i;
`else
          quota_q[c] <= req_wdata_i;
`endif
        end
      end

      for (int unsigned i = 0; i < N_W; i++) begin
        if (wr_ok && dec_sel_weight && (32'(dec_widx) == i)) begin
`ifdef MCCU_CFG_SHADOW_EN
          weight_sh[i] <= req_wdata_i[WEIGHTS_WIDTH-1:0];
`else
          weight_q[i] <= req_wdata_i[WEIGHTS_WIDTH-1:0];
`endif
        end
      end
    end
  end

  always_comb begin
    quota_o   = '0;
    weights_o = '0;
    for (int unsigned c = 0; c < N_CORES; c++)
      quota_o[c*DATA_WIDTH +: DATA_WIDTH] = quota_q[c];
    for (int unsigned i = 0; i < N_W; i++)
      weights_o[i*WEIGHTS_WIDTH +: WEIGHTS_WIDTH] = weight_q[i];
  end

  assign mccu_en_o   = en_q;
  assign irq_o       = irq_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_mccu_cfg_regs.sv
module tb_mccu_cfg_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mccu_en;
  logic [63:0] quota;
  logic [79:0] weights;
  logic [1:0]  mccu_irq = '0;
  logic        irq;

  int unsigned checks = 0;
  int unsigned failures = 0;

  logic [63:0] pre_quota, post_quota;
  logic        post_en;
  logic [31:0] rd;
  logic        er;

  mccu_cfg_regs #(
    .DATA_WIDTH    (32),
    .WEIGHTS_WIDTH (10),
    .N_CORES       (2),
    .CORE_EVENTS   (4),
    .ADDR_WIDTH    (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .mccu_en_o   (mccu_en),
    .quota_o     (quota),
    .weights_o   (weights),
    .mccu_irq_i  (mccu_irq),
    .irq_o       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One full transaction; snapshots outputs just before and just after the accept edge.
  task automatic access(input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err);
    int unsigned n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL req_ready_timeout actual=0 required=1");
    end
    pre_quota = quota;
    @(posedge clk); #1;
    post_quota = quota;
    post_en = mccu_en;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++; failures++;
      $display("FAIL rsp_valid_timeout actual=0 required=1");
    end
    rdata = rsp_rdata;
    err = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h14, 32'h0000_1234, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 8'h14, 32'h0,         32'h0000_1234, 1'b0};
    vecs[2]  = '{1'b1, 8'h4C, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 8'h4C, 32'h0,         32'h0000_03FF, 1'b0};
    vecs[4]  = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vecs[5]  = '{1'b0, 8'h08, 32'h0,         32'h0000_0003, 1'b0};
    vecs[6]  = '{1'b0, 8'h0E, 32'h0,         32'h0,         1'b1};
    vecs[7]  = '{1'b0, 8'h30, 32'h0,         32'h0,         1'b1};
    vecs[8]  = '{1'b1, 8'h30, 32'h0000_DEAD, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 8'h0C, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b0, 8'h60, 32'h0,         32'h0,         1'b1};
    vecs[11] = '{1'b0, 8'h5C, 32'h0,         32'h0,         1'b0};
    vecs[12] = '{1'b1, 8'h00, 32'h0000_0003, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 8'h00, 32'h0,         32'h0000_0001, 1'b0};
    vecs[14] = '{1'b1, 8'h10, 32'hA5A5_A5A5, 32'h0,         1'b0};
    vecs[15] = '{1'b0, 8'h10, 32'h0,         32'hA5A5_A5A5, 1'b0};

    // reset state
    #12;
    check("rst_req_ready", 80'(req_ready), 80'h0);
    check("rst_rsp_valid", 80'(rsp_valid), 80'h0);
    check("rst_rsp_rdata", 80'(rsp_rdata), 80'h0);
    check("rst_rsp_err",   80'(rsp_err),   80'h0);
    check("rst_quota",     80'(quota),     80'h0);
    check("rst_weights",   weights,        80'h0);
    check("rst_en",        80'(mccu_en),   80'h0);
    check("rst_irq",       80'(irq),       80'h0);
    @(negedge clk); rst = 1'b0;
    #1;
    check("post_rst_req_ready", 80'(req_ready), 80'h1);

    // write timing: quota changes on the accept edge, not before
    access(1'b1, 8'h14, 32'h0000_1234, rd, er);
    check("quota1_before_accept", 80'(pre_quota[63:32]), 80'h0);
`ifdef MCCU_CFG_SHADOW_EN
    check("quota1_after_accept", 80'(post_quota[63:32]), 80'h0);
`else
    check("quota1_after_accept", 80'(post_quota[63:32]), 80'h1234);
`endif

    for (int i = 0; i < 16; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("vec%0d_rdata", i), 80'(rd), 80'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_err", i),   80'(er), 80'(vecs[i].exp_err));
    end

    // CTRL=3 at vec12 commits quota1/weight3 in shadow mode; quota0 written after that
`ifdef MCCU_CFG_SHADOW_EN
    check("out_quota", 80'(quota), 80'h0000_1234_0000_0000);
`else
    check("out_quota", 80'(quota), 80'h0000_1234_A5A5_A5A5);
`endif
    check("out_weight03", 80'(weights[39:30]), 80'h3FF);
    check("out_weights_other", 80'(weights[29:0]) | 80'(weights[79:40]), 80'h0);
    check("out_en", 80'(mccu_en), 80'h1);

    // IRQ: mask core1 only
    access(1'b1, 8'h08, 32'h2, rd, er);
    @(negedge clk); mccu_irq = 2'b10;
    @(negedge clk); mccu_irq = 2'b00;
    repeat (2) @(negedge clk);
    access(1'b0, 8'h04, 32'h0, rd, er);
    check("irq_status_set", 80'(rd), 80'h2);
    check("irq_out_set", 80'(irq), 80'h1);
    @(negedge clk); mccu_irq = 2'b10;
    access(1'b1, 8'h04, 32'h2, rd, er);
    access(1'b0, 8'h04, 32'h0, rd, er);
    check("irq_set_wins_w1c", 80'(rd), 80'h2);
    @(negedge clk); mccu_irq = 2'b00;
    @(negedge clk);
    access(1'b1, 8'h04, 32'h2, rd, er);
    access(1'b0, 8'h04, 32'h0, rd, er);
    check("irq_status_cleared", 80'(rd), 80'h0);
    repeat (2) @(negedge clk);
    check("irq_out_cleared", 80'(irq), 80'h0);
    // masked core0 interrupt sets status but not irq_o
    @(negedge clk); mccu_irq = 2'b01;
    @(negedge clk); mccu_irq = 2'b00;
    repeat (2) @(negedge clk);
    access(1'b0, 8'h04, 32'h0, rd, er);
    check("irq_masked_status", 80'(rd), 80'h1);
    check("irq_masked_out", 80'(irq), 80'h0);
    access(1'b1, 8'h04, 32'hFFFF_FFFF, rd, er);
    access(1'b0, 8'h04, 32'h0, rd, er);
    check("irq_status_upper_ignored", 80'(rd), 80'h0);

    // stalled error response stays stable
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h0E; req_wdata = '0;
    @(posedge clk); #1; req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_rsp_valid", k), 80'(rsp_valid), 80'h1);
      check($sformatf("stall%0d_err", k),       80'(rsp_err),   80'h1);
      check($sformatf("stall%0d_rdata", k),     80'(rsp_rdata), 80'h0);
      check($sformatf("stall%0d_req_ready", k), 80'(req_ready), 80'h0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;
    @(negedge clk);
    check("stall_done_req_ready", 80'(req_ready), 80'h1);
    check("stall_done_rsp_valid", 80'(rsp_valid), 80'h0);

    // shadow / direct update and commit
    access(1'b1, 8'h10, 32'd100, rd, er);
`ifdef MCCU_CFG_SHADOW_EN
    check("quota0_write", 80'(post_quota[31:0]), 80'h0);
`else
    check("quota0_write", 80'(post_quota[31:0]), 80'd100);
`endif
    access(1'b1, 8'h00, 32'h0, rd, er);
    check("en_cleared", 80'(post_en), 80'h0);
    access(1'b1, 8'h00, 32'h3, rd, er);
    check("commit_quota0", 80'(post_quota[31:0]), 80'd100);
    check("commit_en", 80'(post_en), 80'h1);

    // reset while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h14;
    @(posedge clk); #1; req_valid = 1'b0;
    check("midrst_rsp_pending", 80'(rsp_valid), 80'h1);
    rst = 1'b1; #1;
    check("midrst_rsp_dropped", 80'(rsp_valid), 80'h0);
    check("midrst_req_ready", 80'(req_ready), 80'h0);
    @(negedge clk); rst = 1'b0; #1;
    check("midrst_after_ready", 80'(req_ready), 80'h1);
    check("midrst_quota", 80'(quota), 80'h0);
    check("midrst_en", 80'(mccu_en), 80'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
